// File: rtl/rot_led_sequencer.sv
// Rotary-encoder driven 8-LED ring sequencer with ROTATE, BAR and AUTO modes.
// Detents and button presses are rising-edge qualified against one registered copy of each input.
module rot_led_sequencer #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rot_event,
  input  logic       rot_dir,
  input  logic       btn,
  output logic [7:0] led,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BAR    = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);

  mode_e       mode_q, mode_d;
  logic [7:0]  led_q, led_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  speed_q, speed_d;
  logic [23:0] presc_q, presc_d;
  logic [3:0]  step_q, step_d;
  logic        ev_q, ev_d;
  logic        bt_q, bt_d;

  logic        detent;
  logic        press;
  logic [3:0]  step_inc;
  logic [7:0]  led_rotl;
  logic [7:0]  led_rotr;

  function automatic logic [7:0] bar_pattern(input logic [3:0] lvl);
    logic [8:0] ones;
    ones = (9'd1 << lvl) - 9'd1;
    return ones[7:0];
  endfunction

  assign detent   = rot_event & ~ev_q;
  assign press    = btn & ~bt_q;
  assign step_inc = step_q + 4'd1;
  assign led_rotl = {led_q[6:0], led_q[7]};
  assign led_rotr = {led_q[0], led_q[7:1]};

  always_comb begin
    mode_d  = mode_q;
    led_d   = led_q;
    level_d = level_q;
    speed_d = speed_q;
    presc_d = presc_q;
    step_d  = step_q;
    ev_d    = rot_event;
    bt_d    = btn;

    // A press wins over a coincident detent: the detent is simply not examined.
    if (press) begin
      presc_d = '0;
      step_d  = '0;
      unique case (mode_q)
        MODE_ROTATE: begin
          mode_d  = MODE_BAR;
          level_d = '0;
          led_d   = '0;
        end
        MODE_BAR: begin
          mode_d  = MODE_AUTO;
          led_d   = 8'h01;
          speed_d = 4'd4;
        end
        MODE_AUTO, MODE_RSVD: begin
          mode_d = MODE_ROTATE;
          led_d  = 8'h01;
        end
      endcase
    end else begin
      unique case (mode_q)
        MODE_ROTATE: begin
          presc_d = '0;
          step_d  = '0;
          if (detent) led_d = rot_dir ? led_rotl : led_rotr;
        end
        MODE_BAR: begin
          presc_d = '0;
          step_d  = '0;
          if (detent) begin
            if (rot_dir && level_q != 4'd8)       level_d = level_q + 4'd1;
            else if (!rot_dir && level_q != 4'd0) level_d = level_q - 4'd1;
          end
          led_d = bar_pattern(level_d);
        end
        MODE_AUTO: begin
          if (detent) begin
            if (rot_dir && speed_q != 4'd8)       speed_d = speed_q + 4'd1;
            else if (!rot_dir && speed_q != 4'd1) speed_d = speed_q - 4'd1;
          end
          // Threshold uses the registered speed, so a step count already past a
          // lowered threshold rotates on the very next tick without being cleared.
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (step_inc >= (4'd9 - speed_q)) begin
              led_d  = led_rotl;
              step_d = '0;
            end else begin
              step_d = step_inc;
            end
          end else begin
            presc_d = presc_q + 24'd1;
          end
        end
        MODE_RSVD: begin
          mode_d  = MODE_ROTATE;
          led_d   = 8'h01;
          presc_d = '0;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_ROTATE;
      led_q   <= 8'h01;
      level_q <= '0;
      speed_q <= 4'd4;
      presc_q <= '0;
      step_q  <= '0;
      ev_q    <= 1'b1;
      bt_q    <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      led_q   <= led_d;
      level_q <= level_d;
      speed_q <= speed_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      ev_q    <= ev_d;
      bt_q    <= bt_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_rot_led_sequencer.sv
// Directed self-checking bench for rot_led_sequencer with TICK_DIV=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_rot_led_sequencer;

  logic       clk;
  logic       reset;
  logic       rot_event;
  logic       rot_dir;
  logic       btn;
  logic [7:0] led;
  logic [1:0] mode;

  int checks = 0;
  int passed = 0;

  rot_led_sequencer #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rot_event (rot_event),
    .rot_dir   (rot_dir),
    .btn       (btn),
    .led       (led),
    .mode      (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic detent(input logic dir);
    rot_dir   = dir;
    rot_event = 1'b1;
    tick();
    rot_event = 1'b0;
    tick();
  endtask

  task automatic press();
    btn = 1'b1;
    tick();
    btn = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rot_event = 1'b0;
    btn       = 1'b0;
    rot_dir   = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; rot_event = 1'b0; btn = 1'b0; rot_dir = 1'b0;
    tick();
    tick();
    checks++;
    if (led !== 8'h01) $display("FAIL reset_led: led=%h expected 01", led);
    else passed++;
    checks++;
    if (mode !== 2'b00) $display("FAIL reset_mode: mode=%b expected 00", mode);
    else passed++;
    reset = 1'b0;
    tick();
    checks++;
    if (led !== 8'h01 || mode !== 2'b00)
      $display("FAIL reset_release: led=%h mode=%b expected 01/00", led, mode);
    else passed++;
  endtask

  task automatic test_rotate();
    logic [7:0] exp_cw  [0:2];
    logic [7:0] exp_ccw [0:3];
    exp_cw  = '{8'h02, 8'h04, 8'h08};
    exp_ccw = '{8'h04, 8'h02, 8'h01, 8'h80};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      detent(1'b1);
      checks++;
      if (led !== exp_cw[i]) $display("FAIL rotate_cw[%0d]: led=%h expected %h", i, led, exp_cw[i]);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      detent(1'b0);
      checks++;
      if (led !== exp_ccw[i]) $display("FAIL rotate_ccw[%0d]: led=%h expected %h", i, led, exp_ccw[i]);
      else passed++;
    end
    checks++;
    if (mode !== 2'b00) $display("FAIL rotate_mode: mode=%b expected 00", mode);
    else passed++;
  endtask

  task automatic test_bar();
    logic [7:0] exp_up [0:9];
    logic [7:0] exp_dn [0:8];
    exp_up = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    exp_dn = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00};
    do_reset();
    press();
    checks++;
    if (mode !== 2'b01 || led !== 8'h00)
      $display("FAIL bar_entry: mode=%b led=%h expected 01/00", mode, led);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      detent(1'b1);
      checks++;
      if (led !== exp_up[i]) $display("FAIL bar_up[%0d]: led=%h expected %h", i, led, exp_up[i]);
      else passed++;
    end
    for (int i = 0; i < 9; i++) begin
      detent(1'b0);
      checks++;
      if (led !== exp_dn[i]) $display("FAIL bar_down[%0d]: led=%h expected %h", i, led, exp_dn[i]);
      else passed++;
    end
  endtask

  task automatic test_auto();
    do_reset();
    press();
    btn = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b10 || led !== 8'h01)
      $display("FAIL auto_entry: mode=%b led=%h expected 10/01", mode, led);
    else passed++;
    btn = 1'b0;
    repeat (19) tick();
    checks++;
    if (led !== 8'h01) $display("FAIL auto_before_step: led=%h expected 01", led);
    else passed++;
    tick();
    checks++;
    if (led !== 8'h02) $display("FAIL auto_step_speed4: led=%h expected 02", led);
    else passed++;
    detent(1'b1);
    checks++;
    if (led !== 8'h02) $display("FAIL auto_detent_no_rotate: led=%h expected 02", led);
    else passed++;
    repeat (3) detent(1'b1);
    checks++;
    if (led !== 8'h04) $display("FAIL auto_speed8_first: led=%h expected 04", led);
    else passed++;
    repeat (3) tick();
    checks++;
    if (led !== 8'h04) $display("FAIL auto_speed8_hold: led=%h expected 04", led);
    else passed++;
    tick();
    checks++;
    if (led !== 8'h08) $display("FAIL auto_speed8_tick2: led=%h expected 08", led);
    else passed++;
    repeat (4) tick();
    checks++;
    if (led !== 8'h10) $display("FAIL auto_speed8_tick3: led=%h expected 10", led);
    else passed++;
    btn = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b00 || led !== 8'h01)
      $display("FAIL auto_to_rotate: mode=%b led=%h expected 00/01", mode, led);
    else passed++;
    btn = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    rot_dir = 1'b1; btn = 1'b1; rot_event = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b01 || led !== 8'h00)
      $display("FAIL same_cycle_press: mode=%b led=%h expected 01/00", mode, led);
    else passed++;
    btn = 1'b0;
    repeat (50) tick();
    checks++;
    if (led !== 8'h00) $display("FAIL same_cycle_discard: led=%h expected 00", led);
    else passed++;
    rot_event = 1'b0;
    tick();
    rot_event = 1'b1;
    tick();
    checks++;
    if (led !== 8'h01) $display("FAIL same_cycle_next_detent: led=%h expected 01", led);
    else passed++;
    do_reset();
    rot_dir = 1'b1; rot_event = 1'b1;
    repeat (50) tick();
    checks++;
    if (led !== 8'h02) $display("FAIL held_single_event: led=%h expected 02", led);
    else passed++;
    rot_event = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    press();
    press();
    repeat (6) tick();
    rot_dir = 1'b1; rot_event = 1'b1; btn = 1'b1; reset = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b00 || led !== 8'h01)
      $display("FAIL reset_mid_auto: mode=%b led=%h expected 00/01", mode, led);
    else passed++;
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (mode !== 2'b00 || led !== 8'h01)
      $display("FAIL reset_held_inputs: mode=%b led=%h expected 00/01", mode, led);
    else passed++;
    rot_event = 1'b0;
    tick();
    rot_event = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b00 || led !== 8'h02)
      $display("FAIL reset_then_detent: mode=%b led=%h expected 00/02", mode, led);
    else passed++;
    btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b01 || led !== 8'h00)
      $display("FAIL reset_then_press: mode=%b led=%h expected 01/00", mode, led);
    else passed++;
    btn = 1'b0; rot_event = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bar();
    test_auto();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rot_led_sequencer.md
ROT_LED_SEQUENCER -- requirements
Module: rot_led_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per AUTO-mode base tick (legal range 2..2^24).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 rot_event  input  1  level-type detent indication from the rotary decoder; a rising edge marks one detent.
REQ-005 rot_dir  input  1  detent direction, valid whenever rot_event is high; 1 = clockwise, 0 = counter-clockwise.
REQ-006 btn  input  1  debounced mode push-button, level; a rising edge advances the mode.
REQ-007 led  output  8  registered LED ring drive, bit 0 = LED0.
REQ-008 mode  output  2  registered current mode; 00 ROTATE, 01 BAR, 10 AUTO.

Function
REQ-009 Edge detection SHALL use one registered copy each of rot_event (ev_q) and btn (bt_q); a detent SHALL be (rot_event=1 and ev_q=0); a press SHALL be (btn=1 and bt_q=0).
REQ-010 Latency: led and mode SHALL change on the same clk edge that samples the qualifying edge, so outputs reflect the event one cycle after the input rises.
REQ-011 Held-high rot_event or btn SHALL produce exactly one event; a new event requires the input to return low for at least one cycle.
REQ-012 Mode FSM: ROTATE -> BAR -> AUTO -> ROTATE, one transition per press; any transition out of encoding 11 SHALL go to ROTATE on the next clk edge.
REQ-013 Press and detent in the same cycle: the press SHALL take effect and the detent SHALL be discarded.
REQ-014 Mode entry initialisation: entering ROTATE -> led=8'h01; entering BAR -> level=0, led=8'h00; entering AUTO -> led=8'h01, speed=4, prescaler=0, step count=0.
REQ-015 ROTATE: a detent with rot_dir=1 SHALL rotate left (led[i+1]<=led[i], led[0]<=led[7]); rot_dir=0 SHALL rotate right (led[i]<=led[i+1], led[7]<=led[0]).
REQ-016 BAR: internal 4-bit level 0..8; rot_dir=1 increments, saturating at 8; rot_dir=0 decrements, saturating at 0; led SHALL equal (1<<level)-1 (level 8 -> 8'hFF).
REQ-017 AUTO: internal speed 1..8; rot_dir=1 increments, rot_dir=0 decrements, saturating at both ends; detents SHALL NOT rotate led directly.
REQ-018 AUTO prescaler: counts 0..TICK_DIV-1 and wraps; a tick is issued on the cycle the count equals TICK_DIV-1.
REQ-019 AUTO step count: increments on each tick; when the incremented value is >= 9-speed, led SHALL rotate left one position on that same edge and the step count SHALL clear to 0.
REQ-020 A speed change SHALL NOT clear the prescaler or step count; a step count already >= the new threshold SHALL rotate on the next tick.
REQ-021 In ROTATE and BAR the prescaler and step count SHALL hold at 0.
REQ-022 Exactly one led bit SHALL be set in ROTATE and AUTO at all times after reset.

Reset
REQ-023 While reset=1 at a clk edge: mode=00, led=8'h01, level=0, speed=4, prescaler=0, step count=0, ev_q=1, bt_q=1.
REQ-024 reset SHALL override all events in the same cycle; ev_q=bt_q=1 SHALL prevent inputs already high at reset release from producing an event.
REQ-025 Reset asserted mid-operation in any mode SHALL return every output to the REQ-023 values on that edge.

Verification (TICK_DIV=4)
REQ-026 Reset, then 3 detents with rot_dir=1 -> led 8'h02, 8'h04, 8'h08; then 4 detents with rot_dir=0 -> led ends at 8'h80 (wrap).
REQ-027 One press, then 10 detents with rot_dir=1 -> mode=01, led=8'hFF (saturated at level 8); then 9 detents with rot_dir=0 -> led=8'h00.
REQ-028 Two presses -> mode=10, led=8'h01; with speed 4, led=8'h02 after 20 clk cycles (5 ticks); 4 detents with rot_dir=1 -> speed=8, led then rotates on every tick (every 4 cycles).
REQ-029 btn and rot_event rise in the same cycle while in ROTATE -> mode=01, led=8'h00, no rotation applied; rot_event held high for 50 cycles -> exactly one event.
REQ-030 Reset asserted in AUTO mid-tick with rot_event and btn high -> mode=00, led=8'h01; after reset release with both inputs still high -> no event until each input toggles low and back high.
